// File: rtl/activation_packer.sv
// activation_packer
//   Tail of the dot-product result stream. Each accepted 2W-bit signed
//   accumulator is rescaled to W-bit fixed point (round half up, shift by
//   FRAC), optionally ReLU-clamped, saturated, and written into the next slot
//   of a D-element vector. When D elements are in, the vector is held behind
//   a valid/ready handshake until the next layer takes it.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   in_acc      signed accumulator (2*W bits)
//   in_v        in_acc valid; beat transfers when in_v && in_ready
//   in_ready    registered; high while collecting
//   packed_out  D*W vector, element i at [W*(D-i-1) +: W] (element 0 in MSBs)
//   out_v       registered; high while a complete vector is held
//   out_ready   downstream accepts the vector when out_v && out_ready
//   sat_flag    sticky: some element saturated since reset

// Per-beat conversion: round, shift, ReLU, saturate. Purely combinational.
module activation_packer_conv #(
   parameter int W    = 16,
   parameter int FRAC = 12,
   parameter int RELU = 1
) (
   input  logic [2*W-1:0] acc,
   output logic [W-1:0]   elem,
   output logic           sat
);
   localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic signed [2*W:0] ONE  = 1;
   localparam logic signed [2*W:0] RND  = (FRAC > 0) ? (ONE <<< RSH) : '0;
   localparam logic signed [2*W:0] MAXV = (ONE <<< (W - 1)) - ONE;
   localparam logic signed [2*W:0] MINV = -(ONE <<< (W - 1));

   // One extra bit so adding the rounding constant can never wrap.
   logic signed [2*W:0] r;
   logic signed [2*W:0] s;

   always_comb begin
      r    = $signed({acc[2*W-1], acc}) + RND;
      s    = r >>> FRAC;
      // ReLU runs before the range check, so a clamp to zero is never
      // counted as saturation.
      if (RELU != 0 && s < 0) s = '0;
      sat  = 1'b0;
      elem = s[W-1:0];
      if (s > MAXV) begin
         elem = MAXV[W-1:0];
         sat  = 1'b1;
      end else if (s < MINV) begin
         elem = MINV[W-1:0];
         sat  = 1'b1;
      end
   end
endmodule

module activation_packer #(
   parameter int W    = 16,
   parameter int D    = 8,
   parameter int FRAC = 12,
   parameter int RELU = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2*W-1:0]   in_acc,
   input  logic             in_v,
   output logic             in_ready,
   output logic [D*W-1:0]   packed_out,
   output logic             out_v,
   input  logic             out_ready,
   output logic             sat_flag
);
   localparam int IW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic {COLLECT, FULL} state_t;

   state_t                state;
   logic [IW-1:0]         idx;
   logic [D-1:0][W-1:0]   slots;
   logic [W-1:0]          elem;
   logic                  elem_sat;
   logic                  accept;
   logic [IW-1:0]         slot_sel;

   activation_packer_conv #(.W(W), .FRAC(FRAC), .RELU(RELU)) u_conv (
      .acc  (in_acc),
      .elem (elem),
      .sat  (elem_sat)
   );

   // in_ready is only ever high in COLLECT, so accept never fires in FULL.
   assign accept   = in_v && in_ready;
   // Element idx lives in the slot counted down from the MSB end.
   assign slot_sel = IW'(D - 1) - idx;
   assign packed_out = slots;

   // in_ready/out_v are loaded together with the next state so they always
   // mirror it without any combinational path from in_v or out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= COLLECT;
         idx      <= '0;
         in_ready <= 1'b1;
         out_v    <= 1'b0;
         slots    <= '0;
         sat_flag <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  slots[slot_sel] <= elem;
                  if (elem_sat) sat_flag <= 1'b1;
                  if (idx == IW'(D - 1)) begin
                     idx      <= '0;
                     state    <= FULL;
                     in_ready <= 1'b0;
                     out_v    <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            FULL: begin
               // Returning to COLLECT costs one cycle: the beat waiting
               // upstream is taken on the following edge, not this one.
               if (out_ready) begin
                  state    <= COLLECT;
                  in_ready <= 1'b1;
                  out_v    <= 1'b0;
               end
            end
            default: begin
               state    <= COLLECT;
               idx      <= '0;
               in_ready <= 1'b1;
               out_v    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_activation_packer.sv
module tb_activation_packer;
   localparam int W = 16;
   localparam int D = 8;
   localparam int FRAC = 12;

   typedef logic [2*W-1:0] vec_t [D];

   logic clk = 1'b0;
   logic rst;
   logic [2*W-1:0] in_acc;
   logic in_v;
   logic out_ready;
   logic in_ready1, out_v1, sat1;
   logic in_ready0, out_v0, sat0;
   logic [D*W-1:0] pk1, pk0;

   int nchk = 0;
   int nfail = 0;
   bit exp_sat1, exp_sat0;

   always #5 clk = ~clk;

   activation_packer #(.W(W), .D(D), .FRAC(FRAC), .RELU(1)) dut1 (
      .clk(clk), .rst(rst), .in_acc(in_acc), .in_v(in_v), .in_ready(in_ready1),
      .packed_out(pk1), .out_v(out_v1), .out_ready(out_ready), .sat_flag(sat1));

   activation_packer #(.W(W), .D(D), .FRAC(FRAC), .RELU(0)) dut0 (
      .clk(clk), .rst(rst), .in_acc(in_acc), .in_v(in_v), .in_ready(in_ready0),
      .packed_out(pk0), .out_v(out_v0), .out_ready(out_ready), .sat_flag(sat0));

   // Reference: real-number rescale as floor((acc + half) / 2^FRAC), then clamp.
   function automatic logic [W-1:0] ref_elem(input logic [2*W-1:0] acc, input bit relu,
                                             output bit sat);
      longint a, s;
      a = longint'($signed(acc));
      if (FRAC > 0) s = (a + (longint'(1) << (FRAC - 1))) >>> FRAC;
      else s = a;
      sat = 1'b0;
      if (relu && s < 0) s = 0;
      if (s > 32767) begin s = 32767; sat = 1'b1; end
      else if (s < -32768) begin s = -32768; sat = 1'b1; end
      return s[W-1:0];
   endfunction

   function automatic logic [D*W-1:0] ref_vec(input vec_t v, input bit relu, output bit sat);
      logic [D*W-1:0] r;
      bit s1;
      r = '0;
      sat = 1'b0;
      for (int i = 0; i < D; i++) begin
         r[W*(D-i-1) +: W] = ref_elem(v[i], relu, s1);
         sat |= s1;
      end
      return r;
   endfunction

   function automatic logic [2*W-1:0] rand_acc();
      case ($urandom_range(3))
         0: return $urandom;
         1: return 32'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
         2: return 32'($urandom_range(0, 32'h0000_FFFF)) - 32'h0000_8000;
         default: return 32'($urandom_range(0, 32'h07FF_FFFF));
      endcase
   endfunction

   // Drive D beats (with optional idle gaps); optionally keep presenting the
   // next vector's first beat once the vector is complete.
   task automatic drive_vector(input vec_t v, input int gap_pct, input bit hold,
                               input logic [2*W-1:0] next_acc);
      for (int i = 0; i < D; i++) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            repeat ($urandom_range(1, 2)) begin
               in_v = 1'b0;
               in_acc = $urandom;
               @(posedge clk); #1;
            end
         end
         in_v = 1'b1;
         in_acc = v[i];
         @(posedge clk); #1;
      end
      in_v = hold;
      in_acc = hold ? next_acc : '0;
   endtask

   task automatic release_vector();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_v = 1'b0; in_acc = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nchk++;
      if ({in_ready1, out_v1, sat1, pk1} !== {3'b100, {D*W{1'b0}}} ||
          {in_ready0, out_v0, sat0, pk0} !== {3'b100, {D*W{1'b0}}}) begin
         nfail++;
         $display("FAIL reset: got rdy=%b/%b v=%b/%b sat=%b/%b pk=%h/%h want rdy=1 v=0 sat=0 pk=0",
                  in_ready1, in_ready0, out_v1, out_v0, sat1, sat0, pk1, pk0);
      end
      rst = 1'b0;
      exp_sat1 = 1'b0; exp_sat0 = 1'b0;
   endtask

   task automatic test_rounding();
      vec_t v;
      for (int i = 0; i < D; i++) v[i] = '0;
      v[0] = 32'h0000_0800;
      v[1] = 32'h0000_07FF;
      drive_vector(v, 0, 1'b0, '0);
      nchk++;
      if (pk1 !== 128'h0001_0000_0000_0000_0000_0000_0000_0000 || pk0 !== pk1 ||
          sat1 !== 1'b0 || sat0 !== 1'b0 || out_v1 !== 1'b1) begin
         nfail++;
         $display("FAIL rounding: got pk=%h/%h sat=%b/%b v=%b want pk=0001_0000..0 sat=0 v=1",
                  pk1, pk0, sat1, sat0, out_v1);
      end
      release_vector();
   endtask

   task automatic test_relu();
      vec_t v;
      logic [D*W-1:0] e1, e0;
      bit s1, s0;
      v[0] = 32'hFF00_0000;
      for (int i = 1; i < D; i++) v[i] = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      e1 = ref_vec(v, 1'b1, s1);
      e0 = ref_vec(v, 1'b0, s0);
      drive_vector(v, 0, 1'b0, '0);
      nchk++;
      if (pk1[D*W-1 -: W] !== 16'h0000 || pk0[D*W-1 -: W] !== 16'hF000 || sat1 !== 1'b0 ||
          sat0 !== 1'b0) begin
         nfail++;
         $display("FAIL relu_elem0: got e0=%h/%h sat=%b/%b want 0000/F000 sat=0",
                  pk1[D*W-1 -: W], pk0[D*W-1 -: W], sat1, sat0);
      end
      nchk++;
      if (pk1 !== e1 || pk0 !== e0) begin
         nfail++;
         $display("FAIL relu_vec: got %h/%h want %h/%h", pk1, pk0, e1, e0);
      end
      release_vector();
   endtask

   task automatic test_basic();
      vec_t v;
      for (int i = 0; i < D; i++) v[i] = 32'(i + 1) << 24;
      out_ready = 1'b1;
      drive_vector(v, 0, 1'b0, '0);
      // Element 7 is 8<<12 = 32768, one past the W-bit maximum, so it clamps.
      nchk++;
      if (pk1 !== 128'h1000_2000_3000_4000_5000_6000_7000_7FFF || pk0 !== pk1 ||
          out_v1 !== 1'b1 || out_v0 !== 1'b1 || in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
         nfail++;
         $display("FAIL basic_full: got pk=%h/%h v=%b/%b rdy=%b/%b want pk=1000_..._7000_7FFF v=1 rdy=0",
                  pk1, pk0, out_v1, out_v0, in_ready1, in_ready0);
      end
      exp_sat1 = 1'b1; exp_sat0 = 1'b1;
      nchk++;
      if (sat1 !== exp_sat1 || sat0 !== exp_sat0) begin
         nfail++;
         $display("FAIL basic_sat: got %b/%b want 1/1", sat1, sat0);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      nchk++;
      if (out_v1 !== 1'b0 || in_ready1 !== 1'b1 || out_v0 !== 1'b0 || in_ready0 !== 1'b1) begin
         nfail++;
         $display("FAIL basic_release: got v=%b/%b rdy=%b/%b want v=0 rdy=1",
                  out_v1, out_v0, in_ready1, in_ready0);
      end
   endtask

   task automatic test_saturation();
      vec_t v;
      for (int i = 0; i < D; i++) v[i] = '0;
      v[0] = 32'h7FFF_FFFF;
      v[1] = 32'h8000_0000;
      drive_vector(v, 0, 1'b0, '0);
      nchk++;
      if (pk0[D*W-1 -: 2*W] !== 32'h7FFF_8000 || pk1[D*W-1 -: 2*W] !== 32'h7FFF_0000 ||
          sat0 !== 1'b1 || sat1 !== 1'b1) begin
         nfail++;
         $display("FAIL saturation: got relu0=%h relu1=%h sat=%b/%b want 7FFF8000 7FFF0000 sat=1",
                  pk0[D*W-1 -: 2*W], pk1[D*W-1 -: 2*W], sat0, sat1);
      end
      release_vector();
      for (int i = 0; i < D; i++) v[i] = 32'h0000_1000;
      drive_vector(v, 0, 1'b0, '0);
      nchk++;
      if (sat0 !== 1'b1 || sat1 !== 1'b1 || pk0 !== {D{16'h0001}}) begin
         nfail++;
         $display("FAIL sat_sticky: got sat=%b/%b pk=%h want sat=1 pk=0001x8", sat0, sat1, pk0);
      end
      release_vector();
   endtask

   task automatic test_reset_mid();
      vec_t v;
      logic [D*W-1:0] e1, e0;
      bit s1, s0;
      for (int i = 0; i < 5; i++) begin
         in_v = 1'b1; in_acc = rand_acc();
         @(posedge clk); #1;
      end
      in_v = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_sat1 = 1'b0; exp_sat0 = 1'b0;
      nchk++;
      if (out_v1 !== 1'b0 || in_ready1 !== 1'b1 || pk1 !== '0 || sat1 !== 1'b0 ||
          out_v0 !== 1'b0 || pk0 !== '0 || sat0 !== 1'b0) begin
         nfail++;
         $display("FAIL reset_mid: got v=%b rdy=%b pk=%h/%h sat=%b/%b want v=0 rdy=1 pk=0 sat=0",
                  out_v1, in_ready1, pk1, pk0, sat1, sat0);
      end
      for (int i = 0; i < D; i++) v[i] = 32'($urandom_range(1, 32'h07FF_FFFF));
      e1 = ref_vec(v, 1'b1, s1);
      e0 = ref_vec(v, 1'b0, s0);
      drive_vector(v, 0, 1'b0, '0);
      nchk++;
      if (pk1 !== e1 || pk0 !== e0 || out_v1 !== 1'b1 || sat1 !== s1 || sat0 !== s0) begin
         nfail++;
         $display("FAIL reset_mid_vec: got %h/%h v=%b sat=%b/%b want %h/%h v=1 sat=%b/%b",
                  pk1, pk0, out_v1, sat1, sat0, e1, e0, s1, s0);
      end
      exp_sat1 = s1; exp_sat0 = s0;
      release_vector();
   endtask

   task automatic test_backpressure();
      vec_t v, v2;
      logic [D*W-1:0] e1, e0, snap;
      logic [2*W-1:0] na;
      bit s1, s0;
      int bad;
      for (int i = 0; i < D; i++) v[i] = rand_acc();
      na = 32'h0003_4000;
      drive_vector(v, 0, 1'b1, na);
      snap = pk1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_v1 !== 1'b1 || in_ready1 !== 1'b0 || pk1 !== snap || in_ready0 !== 1'b0) bad++;
      end
      nchk++;
      if (bad != 0) begin
         nfail++;
         $display("FAIL backpressure_hold: %0d bad cycles, want v=1 rdy=0 pk stable %h", bad, snap);
      end
      release_vector();
      nchk++;
      if (in_ready1 !== 1'b1 || out_v1 !== 1'b0) begin
         nfail++;
         $display("FAIL backpressure_release: got rdy=%b v=%b want rdy=1 v=0", in_ready1, out_v1);
      end
      v2[0] = na;
      for (int i = 1; i < D; i++) v2[i] = rand_acc();
      e1 = ref_vec(v2, 1'b1, s1);
      e0 = ref_vec(v2, 1'b0, s0);
      exp_sat1 |= s1; exp_sat0 |= s0;
      drive_vector(v2, 0, 1'b0, '0);
      nchk++;
      if (pk1 !== e1 || pk0 !== e0 || sat1 !== exp_sat1 || sat0 !== exp_sat0) begin
         nfail++;
         $display("FAIL backpressure_vec: got %h/%h sat=%b/%b want %h/%h sat=%b/%b",
                  pk1, pk0, sat1, sat0, e1, e0, exp_sat1, exp_sat0);
      end
      release_vector();
   endtask

   task automatic test_random();
      vec_t v;
      logic [D*W-1:0] e1, e0;
      bit s1, s0;
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < D; i++) v[i] = rand_acc();
         e1 = ref_vec(v, 1'b1, s1);
         e0 = ref_vec(v, 1'b0, s0);
         exp_sat1 |= s1; exp_sat0 |= s0;
         drive_vector(v, 30, 1'b0, '0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         nchk++;
         if (pk1 !== e1 || pk0 !== e0 || out_v1 !== 1'b1 || in_ready1 !== 1'b0 ||
             sat1 !== exp_sat1 || sat0 !== exp_sat0) begin
            nfail++;
            $display("FAIL random[%0d]: got %h/%h v=%b rdy=%b sat=%b/%b want %h/%h v=1 rdy=0 sat=%b/%b",
                     n, pk1, pk0, out_v1, in_ready1, sat1, sat0, e1, e0, exp_sat1, exp_sat0);
         end
         release_vector();
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_relu();
      test_basic();
      test_saturation();
      test_reset_mid();
      test_backpressure();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
